// File: rtl/testdata_pkg.sv
// Shared definitions for the test-data loader: FSM encoding and default geometry.
package testdata_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadLo,
    StLoadHi,
    StFull
  } loader_state_e;

  localparam int unsigned DefRamWidth    = 16;
  localparam int unsigned DefRamAddrBits = 4;

endpackage

// File: rtl/testdata_loader.sv
// Unpacks a stream of two-sample beats into sequential test-data RAM writes and
// reports when a complete frame is held. The consumer's done pulse is release_req.
module testdata_loader
  import testdata_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = DefRamWidth,
  parameter int unsigned RAM_ADDR_BITS = DefRamAddrBits
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        release_req,
  input  logic [2*RAM_WIDTH-1:0]      s_tdata,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  output logic                        write_enable,
  output logic [RAM_ADDR_BITS-1:0]    write_address,
  output logic signed [RAM_WIDTH-1:0] RAM_in,
  output logic                        load_done,
  output logic                        frame_error,
  output logic [RAM_ADDR_BITS:0]      sample_count
);

  localparam logic [RAM_ADDR_BITS-1:0] LastAddr = '1;

  loader_state_e          state_q;
  logic [RAM_ADDR_BITS-1:0] ptr_q;
  logic [RAM_WIDTH-1:0]     hold_q;
  logic                     last_q;

  logic                     accept;
  logic [RAM_ADDR_BITS-1:0] hi_addr;
  logic                     hi_is_final;

  // Handshake and status are pure decodes of the registered state.
  assign s_tready    = (state_q == StLoadLo);
  assign load_done   = (state_q == StFull);
  assign accept      = s_tvalid & s_tready;
  assign hi_addr     = ptr_q + RAM_ADDR_BITS'(1);
  assign hi_is_final = (hi_addr == LastAddr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      hold_q        <= '0;
      last_q        <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      RAM_in        <= '0;
      frame_error   <= 1'b0;
      sample_count  <= '0;
    end else begin
      write_enable <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ptr_q        <= '0;
            sample_count <= '0;
            frame_error  <= 1'b0;
            state_q      <= StLoadLo;
          end
        end
        StLoadLo: begin
          if (accept) begin
            write_enable  <= 1'b1;
            write_address <= ptr_q;
            RAM_in        <= s_tdata[RAM_WIDTH-1:0];
            hold_q        <= s_tdata[2*RAM_WIDTH-1:RAM_WIDTH];
            last_q        <= s_tlast;
            sample_count  <= sample_count + (RAM_ADDR_BITS+1)'(1);
            state_q       <= StLoadHi;
          end
        end
        StLoadHi: begin
          write_enable  <= 1'b1;
          write_address <= hi_addr;
          RAM_in        <= hold_q;
          sample_count  <= sample_count + (RAM_ADDR_BITS+1)'(1);
          if (hi_is_final || last_q) begin
            // tlast must coincide exactly with the beat that fills the RAM.
            frame_error <= frame_error | (hi_is_final != last_q);
            state_q     <= StFull;
          end else begin
            ptr_q   <= ptr_q + RAM_ADDR_BITS'(2);
            state_q <= StLoadLo;
          end
        end
        StFull: begin
          if (release_req) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_testdata_loader.sv
// Self-checking bench for testdata_loader against a frame-level reference model.
module tb_testdata_loader;

  localparam int W     = 16;
  localparam int A     = 4;
  localparam int Beats = 8;

  logic                clk = 1'b0;
  logic                resetn, start, release_req;
  logic [2*W-1:0]      s_tdata;
  logic                s_tvalid, s_tlast, s_tready;
  logic                write_enable;
  logic [A-1:0]        write_address;
  logic signed [W-1:0] RAM_in;
  logic                load_done, frame_error;
  logic [A:0]          sample_count;

  logic [31:0]  fb_data[Beats];
  logic         fb_last[Beats];
  logic [A-1:0] log_addr[$];
  logic [W-1:0] log_data[$];
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  testdata_loader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .release_req  (release_req),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .write_enable (write_enable),
    .write_address(write_address),
    .RAM_in       (RAM_in),
    .load_done    (load_done),
    .frame_error  (frame_error),
    .sample_count (sample_count)
  );

  // Write log observed on the RAM port, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      log_addr.push_back(write_address);
      log_data.push_back(RAM_in);
    end
  end

  // Reference: a frame ends at the first tlast beat or at the beat that fills the RAM.
  function automatic int exp_beats();
    for (int i = 0; i < Beats; i++) if (fb_last[i]) return i + 1;
    return Beats;
  endfunction

  function automatic logic exp_err();
    return !(exp_beats() == Beats && fb_last[Beats-1]);
  endfunction

  function automatic logic [W-1:0] exp_sample(input int i);
    logic [31:0] b;
    b = fb_data[i/2];
    return (i % 2 == 1) ? b[31:16] : b[15:0];
  endfunction

  task automatic random_frame(input int last_idx);
    for (int i = 0; i < Beats; i++) begin
      fb_data[i] = $urandom;
      fb_last[i] = (i == last_idx);
    end
  endtask

  task automatic pulse_start();
    log_addr.delete();
    log_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input bit rand_valid, input int nsend);
    int   sent = 0;
    int   cyc = 0;
    logic v, rdy;
    while (sent < nsend && cyc < 400) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tvalid = v;
      s_tdata  = fb_data[sent];
      s_tlast  = fb_last[sent];
      rdy      = s_tready;
      @(negedge clk);
      cyc++;
      if (v && rdy) sent++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    vectors++;
    if (sent != nsend) begin
      miscompares++;
      $display("FAIL beats_accepted: got %0d expected %0d", sent, nsend);
    end
  endtask

  task automatic check_frame(input string name);
    int n = 2 * exp_beats();
    int cyc = 0;
    while (load_done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    vectors++;
    if (load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s load_done: got %b expected 1", name, load_done);
    end
    vectors++;
    if (log_addr.size() != n) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d expected %0d", name, log_addr.size(), n);
    end
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      vectors++;
      if (log_addr[i] !== A'(i) || log_data[i] !== exp_sample(i)) begin
        miscompares++;
        $display("FAIL %s write[%0d]: got addr %0d data %h expected addr %0d data %h",
                 name, i, log_addr[i], log_data[i], i, exp_sample(i));
      end
    end
    vectors++;
    if (sample_count !== (A+1)'(n)) begin
      miscompares++;
      $display("FAIL %s sample_count: got %0d expected %0d", name, sample_count, n);
    end
    vectors++;
    if (frame_error !== exp_err()) begin
      miscompares++;
      $display("FAIL %s frame_error: got %b expected %b", name, frame_error, exp_err());
    end
    vectors++;
    if (s_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s s_tready_full: got %b expected 0", name, s_tready);
    end
  endtask

  task automatic do_release(input string name);
    release_req = 1'b1;
    @(negedge clk);
    release_req = 1'b0;
    vectors++;
    if (load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s load_done_after_release: got %b expected 0", name, load_done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({s_tready, write_enable, write_address, RAM_in, load_done, frame_error,
         sample_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy %b we %b addr %0d data %h done %b err %b cnt %0d expected all 0",
               s_tready, write_enable, write_address, RAM_in, load_done, frame_error, sample_count);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < Beats; k++) begin
      fb_data[k] = {16'(2 * k + 2), 16'(2 * k + 1)};
      fb_last[k] = (k == Beats - 1);
    end
    pulse_start();
    send_beats(1'b0, exp_beats());
    check_frame("full_frame");
    do_release("full_frame");
  endtask

  task automatic test_short_frame();
    random_frame(2);
    pulse_start();
    send_beats(1'b0, exp_beats());
    check_frame("short_frame");
    do_release("short_frame");
  endtask

  task automatic test_missing_tlast();
    random_frame(-1);
    pulse_start();
    send_beats(1'b0, exp_beats());
    check_frame("missing_tlast");
    do_release("missing_tlast");
  endtask

  task automatic test_negative();
    random_frame(Beats - 1);
    fb_data[0] = 32'hFFFF_8000;
    fb_data[3] = 32'hFFFF_8000;
    pulse_start();
    send_beats(1'b1, exp_beats());
    check_frame("negative");
    vectors++;
    if (log_data.size() < 2 || $signed(log_data[0]) != -32768 || $signed(log_data[1]) != -1) begin
      miscompares++;
      $display("FAIL negative_values: got %0d,%0d expected -32768,-1",
               $signed(log_data[0]), $signed(log_data[1]));
    end
    do_release("negative");
  endtask

  task automatic test_reset_mid();
    random_frame(-1);
    pulse_start();
    send_beats(1'b0, 4);
    resetn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({s_tready, write_enable, write_address, RAM_in, load_done, frame_error,
         sample_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got rdy %b we %b addr %0d data %h done %b err %b cnt %0d expected all 0",
               s_tready, write_enable, write_address, RAM_in, load_done, frame_error, sample_count);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (log_addr.size() != 7) begin
      miscompares++;
      $display("FAIL reset_mid_writes: got %0d expected 7", log_addr.size());
    end
    random_frame(Beats - 1);
    pulse_start();
    send_beats(1'b1, exp_beats());
    check_frame("reload_after_reset");
    do_release("reload_after_reset");
  endtask

  task automatic test_start_release();
    random_frame(Beats - 1);
    pulse_start();
    send_beats(1'b0, exp_beats());
    check_frame("start_release");
    log_addr.delete();
    log_data.delete();
    start       = 1'b1;
    release_req = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    release_req = 1'b0;
    vectors++;
    if (load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_release_done: got %b expected 0", load_done);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (s_tready !== 1'b0 || log_addr.size() != 0 || sample_count !== 5'd16) begin
      miscompares++;
      $display("FAIL start_release_idle: got rdy %b writes %0d cnt %0d expected 0 0 16",
               s_tready, log_addr.size(), sample_count);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    start       = 1'b0;
    release_req = 1'b0;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_missing_tlast();
    test_negative();
    test_reset_mid();
    test_start_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
